semafor_pieton_param: RTL and testbench

Parametrised pedestrian-crossing controller for one car head (red/yellow/green) and one pedestrian head (red/green). It is the next generation of the lab's fixed-timing crossing light. It adds the following:
- all phase durations set by parameters, counted in time units from an internal prescaler;
- a synchronised, latched pedestrian request;
- a blinking pedestrian-green warning phase;
- an all-red clearance phase;
- a night mode with flashing yellow.

It sits directly between the board button/switch inputs and the LED pins.

---
 rtl/semafor_pieton_param.sv | 154 +++++++++++++++
 tb/tb_semafor_pieton_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/semafor_pieton_param.sv
// Pedestrian-crossing controller: one car head, one pedestrian head.
// Phase timing comes from a prescaled unit timer. Lamps are registered and decoded from the next state.
module semafor_pieton_param #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned T_INIT   = 10,
  parameter int unsigned T_VM_MIN = 60,
  parameter int unsigned T_GM     = 5,
  parameter int unsigned T_VP     = 30,
  parameter int unsigned T_BLINK  = 6,
  parameter int unsigned T_CLR    = 2,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       night,
  output logic       r_m,
  output logic       g_m,
  output logic       v_m,
  output logic       r_p,
  output logic       v_p,
  output logic       req_pending,
  output logic [2:0] state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_VM_RP  = 3'd1,
    S_GM_RP  = 3'd2,
    S_RM_VP  = 3'd3,
    S_RM_VB  = 3'd4,
    S_RM_CLR = 3'd5,
    S_NIGHT  = 3'd6,
    S_BAD    = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          btn_s1_q, btn_s_q, btn_prev_q;
  logic          night_s1_q, night_s_q;
  logic          req_q, req_d;
  logic          r_m_q, g_m_q, v_m_q, r_p_q, v_p_q;
  logic          r_m_d, g_m_d, v_m_d, r_p_d, v_p_d;
  logic          tick;
  logic          btn_rise;
  logic          vm_min_done;

  assign tick        = (pre_q == PW'(TICK_DIV - 1));
  assign btn_rise    = btn_s_q & ~btn_prev_q;
  // Minimum green is reached at this edge or already past it (timer saturates there).
  assign vm_min_done = (tmr_q >= CW'(T_VM_MIN)) || (tick && (tmr_q == CW'(T_VM_MIN - 1)));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   if (tick && (tmr_q == CW'(T_INIT - 1))) state_d = night_s_q ? S_NIGHT : S_VM_RP;
      S_VM_RP: begin
        if (night_s_q)                state_d = S_NIGHT;
        else if (req_q && vm_min_done) state_d = S_GM_RP;
      end
      S_GM_RP:  if (tick && (tmr_q == CW'(T_GM - 1)))            state_d = S_RM_VP;
      S_RM_VP:  if (tick && (tmr_q == CW'(T_VP - T_BLINK - 1)))  state_d = S_RM_VB;
      S_RM_VB:  if (tick && (tmr_q == CW'(T_BLINK - 1)))         state_d = S_RM_CLR;
      S_RM_CLR: if (tick && (tmr_q == CW'(T_CLR - 1)))           state_d = S_VM_RP;
      S_NIGHT:  if (!night_s_q)                                  state_d = S_INIT;
      default:  state_d = S_INIT;
    endcase
  end

  // Timers, request latch and lamp decode from the next state
  always_comb begin
    pre_d = pre_q;
    tmr_d = tmr_q;
    req_d = req_q;
    r_m_d = 1'b0;
    g_m_d = 1'b0;
    v_m_d = 1'b0;
    r_p_d = 1'b0;
    v_p_d = 1'b0;

    if (state_d != state_q) begin
      pre_d = '0;
      tmr_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        case (state_q)
          S_VM_RP: if (tmr_q < CW'(T_VM_MIN)) tmr_d = tmr_q + CW'(1);
          S_NIGHT: tmr_d = tmr_q ^ CW'(1);
          default: tmr_d = tmr_q + CW'(1);
        endcase
      end
    end

    if (btn_rise && !(state_q inside {S_RM_VP, S_RM_VB, S_NIGHT})) req_d = 1'b1;
    if ((state_d != state_q) && ((state_d == S_RM_VP) || (state_d == S_NIGHT))) req_d = 1'b0;

    case (state_d)
      S_VM_RP: begin v_m_d = 1'b1; r_p_d = 1'b1; end
      S_GM_RP: begin g_m_d = 1'b1; r_p_d = 1'b1; end
      S_RM_VP: begin r_m_d = 1'b1; v_p_d = 1'b1; end
      S_RM_VB: begin r_m_d = 1'b1; v_p_d = ~tmr_d[0]; end
      S_NIGHT: g_m_d = ~tmr_d[0];
      default: begin r_m_d = 1'b1; r_p_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      pre_q      <= '0;
      tmr_q      <= '0;
      btn_s1_q   <= 1'b0;
      btn_s_q    <= 1'b0;
      btn_prev_q <= 1'b0;
      night_s1_q <= 1'b0;
      night_s_q  <= 1'b0;
      req_q      <= 1'b0;
      r_m_q      <= 1'b1;
      g_m_q      <= 1'b0;
      v_m_q      <= 1'b0;
      r_p_q      <= 1'b1;
      v_p_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tmr_q      <= tmr_d;
      btn_s1_q   <= btn;
      btn_s_q    <= btn_s1_q;
      btn_prev_q <= btn_s_q;
      night_s1_q <= night;
      night_s_q  <= night_s1_q;
      req_q      <= req_d;
      r_m_q      <= r_m_d;
      g_m_q      <= g_m_d;
      v_m_q      <= v_m_d;
      r_p_q      <= r_p_d;
      v_p_q      <= v_p_d;
    end
  end

  assign r_m         = r_m_q;
  assign g_m         = g_m_q;
  assign v_m         = v_m_q;
  assign r_p         = r_p_q;
  assign v_p         = v_p_q;
  assign req_pending = req_q;
  assign state       = 3'(state_q);

endmodule

// File: tb/tb_semafor_pieton_param.sv
// Bench for semafor_pieton_param: directed vector table, async-reset sequence,
// and random stimulus checked against a phase/cycle-count reference model.
module tb_semafor_pieton_param;

  localparam int unsigned TD   = 4;
  localparam int unsigned TI   = 2;
  localparam int unsigned TVM  = 6;
  localparam int unsigned TGM  = 2;
  localparam int unsigned TVP  = 5;
  localparam int unsigned TBL  = 2;
  localparam int unsigned TCLR = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic       night = 1'b0;
  logic       r_m, g_m, v_m, r_p, v_p, req_pending;
  logic [2:0] state;

  int  n_pass = 0;
  int  n_total = 0;
  bit  chk_en = 1'b0;

  semafor_pieton_param #(
    .TICK_DIV(TD), .T_INIT(TI), .T_VM_MIN(TVM), .T_GM(TGM),
    .T_VP(TVP), .T_BLINK(TBL), .T_CLR(TCLR), .CW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .night(night),
    .r_m(r_m), .g_m(g_m), .v_m(v_m), .r_p(r_p), .v_p(v_p),
    .req_pending(req_pending), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: phase id plus cycles spent in that phase.
  int m_st = 0;
  int m_c = 0;
  bit m_req = 0, m_b1 = 0, m_b2 = 0, m_bp = 0, m_n1 = 0, m_n2 = 0;

  function automatic logic [4:0] exp_lamps(input int st, input int c);
    bit even;
    even = ((c / int'(TD)) % 2) == 0;
    case (st)
      1:       return 5'b00110;
      2:       return 5'b01010;
      3:       return 5'b10001;
      4:       return {4'b1000, even};
      6:       return {1'b0, even, 3'b000};
      default: return 5'b10010;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_c = 0; m_req = 0;
      m_b1 = 0; m_b2 = 0; m_bp = 0; m_n1 = 0; m_n2 = 0;
    end else begin
      int nst;
      nst = m_st;
      case (m_st)
        0: if (m_c == int'(TI * TD) - 1) nst = m_n2 ? 6 : 1;
        1: begin
          if (m_n2) nst = 6;
          else if (m_req && m_c >= int'(TVM * TD) - 1) nst = 2;
        end
        2: if (m_c == int'(TGM * TD) - 1) nst = 3;
        3: if (m_c == int'((TVP - TBL) * TD) - 1) nst = 4;
        4: if (m_c == int'(TBL * TD) - 1) nst = 5;
        5: if (m_c == int'(TCLR * TD) - 1) nst = 1;
        6: if (!m_n2) nst = 0;
        default: nst = 0;
      endcase
      if (m_b2 && !m_bp && m_st != 3 && m_st != 4 && m_st != 6) m_req = 1;
      if (nst != m_st && (nst == 3 || nst == 6)) m_req = 0;
      m_c  = (nst != m_st) ? 0 : m_c + 1;
      m_st = nst;
      m_bp = m_b2; m_b2 = m_b1; m_b1 = btn;
      m_n2 = m_n1; m_n1 = night;
    end
  end

  // Per-cycle model comparison and lamp invariants
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model", {23'd0, state, r_m, g_m, v_m, r_p, v_p, req_pending},
          {23'd0, 3'(m_st), exp_lamps(m_st, m_c), m_req});
      chk("inv_green_conflict", 32'((v_m | g_m) & v_p), 32'd0);
      if (state != 3'd6) chk("inv_one_car_lamp", 32'(r_m + g_m + v_m), 32'd1);
    end
  end

  typedef struct {
    logic       b;
    logic       n;
    int         cyc;
    logic [2:0] st;
    logic       rq;
    logic [4:0] lamps;
  } vec_t;

  function automatic vec_t mk(input logic b, input logic n, input int cyc,
                              input logic [2:0] st, input logic rq, input logic [4:0] lamps);
    vec_t v;
    v.b = b; v.n = n; v.cyc = cyc; v.st = st; v.rq = rq; v.lamps = lamps;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int cnt;
    int hold;
    bit found;

    // lamps = {r_m, g_m, v_m, r_p, v_p}
    vecs.push_back(mk(0, 0, 7,    3'd0, 0, 5'b10010));
    vecs.push_back(mk(0, 0, 1,    3'd1, 0, 5'b00110));
    vecs.push_back(mk(0, 0, 1000, 3'd1, 0, 5'b00110));
    vecs.push_back(mk(1, 0, 2,    3'd1, 0, 5'b00110));
    vecs.push_back(mk(1, 0, 1,    3'd1, 1, 5'b00110));
    vecs.push_back(mk(1, 0, 1,    3'd2, 1, 5'b01010));
    vecs.push_back(mk(0, 0, 7,    3'd2, 1, 5'b01010));
    vecs.push_back(mk(0, 0, 1,    3'd3, 0, 5'b10001));
    vecs.push_back(mk(1, 0, 11,   3'd3, 0, 5'b10001));
    vecs.push_back(mk(0, 0, 1,    3'd4, 0, 5'b10001));
    vecs.push_back(mk(0, 0, 7,    3'd4, 0, 5'b10000));
    vecs.push_back(mk(0, 0, 1,    3'd5, 0, 5'b10010));
    vecs.push_back(mk(0, 0, 3,    3'd5, 0, 5'b10010));
    vecs.push_back(mk(0, 0, 1,    3'd1, 0, 5'b00110));
    vecs.push_back(mk(0, 0, 2,    3'd1, 0, 5'b00110));
    vecs.push_back(mk(1, 0, 3,    3'd1, 1, 5'b00110));
    vecs.push_back(mk(0, 0, 18,   3'd1, 1, 5'b00110));
    vecs.push_back(mk(0, 0, 1,    3'd2, 1, 5'b01010));
    vecs.push_back(mk(0, 0, 7,    3'd2, 1, 5'b01010));
    vecs.push_back(mk(0, 0, 1,    3'd3, 0, 5'b10001));
    vecs.push_back(mk(0, 1, 11,   3'd3, 0, 5'b10001));
    vecs.push_back(mk(0, 1, 1,    3'd4, 0, 5'b10001));
    vecs.push_back(mk(0, 1, 7,    3'd4, 0, 5'b10000));
    vecs.push_back(mk(0, 1, 1,    3'd5, 0, 5'b10010));
    vecs.push_back(mk(0, 1, 3,    3'd5, 0, 5'b10010));
    vecs.push_back(mk(0, 1, 1,    3'd1, 0, 5'b00110));
    vecs.push_back(mk(0, 1, 1,    3'd6, 0, 5'b01000));
    vecs.push_back(mk(0, 1, 20,   3'd6, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 2,    3'd6, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 1,    3'd0, 0, 5'b10010));
    vecs.push_back(mk(0, 0, 7,    3'd0, 0, 5'b10010));
    vecs.push_back(mk(0, 0, 1,    3'd1, 0, 5'b00110));

    // Reset asserted without clocking
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", {26'd0, state, r_m, g_m, v_m, r_p, v_p, req_pending}, {26'd0, 3'd0, 5'b10010, 1'b0});
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_held", {26'd0, state, r_m, r_p, req_pending}, {26'd0, 3'd0, 1'b1, 1'b1, 1'b0});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn   = vecs[i].b;
      night = vecs[i].n;
      repeat (vecs[i].cyc) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_req", i), 32'(req_pending), 32'(vecs[i].rq));
      chk($sformatf("vec%0d_lamps", i), 32'({r_m, g_m, v_m, r_p, v_p}), 32'(vecs[i].lamps));
    end

    // Async reset in the middle of the blinking phase while v_p is lit
    btn = 1'b1;
    cnt = 0;
    found = 1'b0;
    while (cnt < 300 && !found) begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) btn = 1'b0;
      if (state == 3'd4) found = 1'b1;
    end
    btn = 1'b0;
    chk("wait_rm_vb", 32'(found), 32'd1);
    chk("rm_vb_vp_on", 32'(v_p), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_vb", {26'd0, state, r_m, r_p, v_p, req_pending}, {26'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    #1 rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("post_reset_init", 32'(state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_vm", 32'(state), 32'd1);

    // Random stimulus against the reference model
    hold = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) btn = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        btn  = 1'b1;
        hold = int'($urandom_range(2, 5));
      end
      if ($urandom_range(0, 299) == 0) night = ~night;
      if ($urandom_range(0, 1499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
